// File: rtl/dram_responder_pkg.sv
// Shared constants for the DRAM responder: funct3 access codes, size fields
// and the request FSM state encoding.
package dram_responder_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // 011, 110 and 111 are illegal for both loads and stores.
  function automatic logic ctrl_illegal(input logic [2:0] c);
    return (c[1:0] == 2'b11) || (c == 3'b110);
  endfunction

endpackage

// File: rtl/dram_resp_ram.sv
// Single-port synchronous word RAM with byte-lane enables and a registered
// read port (data appears one cycle after the enabled edge). Not reset.
module dram_resp_ram #(
  parameter int DEPTH_WORDS = 4096
) (
  input  logic                           i_clk,
  input  logic                           i_en,
  input  logic                           i_we,
  input  logic [3:0]                     i_be,
  input  logic [$clog2(DEPTH_WORDS)-1:0] i_addr,
  input  logic [31:0]                    i_wdata,
  output logic [31:0]                    o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int b = 0; b < 4; b++) begin
          if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dram_responder.sv
// Responder end of the MMU DRAM port: latches one request, frames it with busy
// for LATENCY cycles, then answers. Optional DRAM_RESPONDER_STATS_EN adds
// good-load / good-store counters.
module dram_responder
  import dram_responder_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          LATENCY     = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] w_dram_addr,
  input  logic [31:0] w_dram_wdata,
  input  logic        w_dram_we_t,
  input  logic        w_dram_le,
  input  logic [2:0]  w_dram_ctrl,
  output logic [31:0] w_dram_odata,
  output logic        w_dram_busy,
  output logic [1:0]  w_dbg_state,
  output logic        w_dram_err
`ifdef DRAM_RESPONDER_STATS_EN
  ,
  output logic [31:0] w_rd_cnt,
  output logic [31:0] w_wr_cnt
`endif
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] WIN_BYTES = 32'(4 * DEPTH_WORDS);
  localparam logic [3:0]  LAT_LOAD  = 4'(LATENCY - 1);

  state_t      r_state, w_next_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_addr, r_wdata, r_odata;
  logic [2:0]  r_ctrl;
  logic        r_is_wr, r_err;

  logic        w_accept, w_commit, w_bad, w_mis, w_oow;
  logic [31:0] w_off, w_ram_rdata, w_ram_wdata, w_shift, w_load_data;
  logic [3:0]  w_be;

  assign w_accept = (r_state == ST_IDLE) && (w_dram_we_t || w_dram_le);
  // RAM access (write commit or read issue) happens on the last WAIT edge so
  // registered read data is ready during DONE.
  assign w_commit = (r_state == ST_WAIT) && (r_cnt == 4'd1);

  assign w_off = r_addr - ADDR_BASE;
  assign w_oow = (w_off >= WIN_BYTES);
  assign w_mis = ((r_ctrl[1:0] == SZ_H) && w_off[0]) ||
                 ((r_ctrl[1:0] == SZ_W) && (w_off[1:0] != 2'b00));
  assign w_bad = w_oow || w_mis || ctrl_illegal(r_ctrl);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next_state = ST_WAIT;
      ST_WAIT: if (r_cnt == 4'd1) w_next_state = ST_DONE;
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_be        = 4'b1111;
    w_ram_wdata = r_wdata;
    case (r_ctrl[1:0])
      SZ_B: begin
        w_be        = 4'b0001 << w_off[1:0];
        w_ram_wdata = {4{r_wdata[7:0]}};
      end
      SZ_H: begin
        w_be        = w_off[1] ? 4'b1100 : 4'b0011;
        w_ram_wdata = {2{r_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign w_shift = w_ram_rdata >> {w_off[1:0], 3'b000};

  always_comb begin
    w_load_data = 32'h0;
    case (r_ctrl)
      F3_LB:   w_load_data = {{24{w_shift[7]}}, w_shift[7:0]};
      F3_LH:   w_load_data = {{16{w_shift[15]}}, w_shift[15:0]};
      F3_LW:   w_load_data = w_shift;
      F3_LBU:  w_load_data = {24'h0, w_shift[7:0]};
      F3_LHU:  w_load_data = {16'h0, w_shift[15:0]};
      default: w_load_data = 32'h0;
    endcase
  end

  dram_resp_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .i_clk   (CLK),
    .i_en    (w_commit),
    .i_we    (r_is_wr && !w_bad),
    .i_be    (w_be),
    .i_addr  (w_off[AW+1:2]),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_ctrl  <= 3'b000;
      r_is_wr <= 1'b0;
      r_odata <= 32'h0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_cnt   <= LAT_LOAD;
        r_addr  <= w_dram_addr;
        r_wdata <= w_dram_wdata;
        r_ctrl  <= w_dram_ctrl;
        r_is_wr <= w_dram_we_t;
      end else if (r_state == ST_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (r_state == ST_DONE) begin
        r_err <= w_bad;
        if (!r_is_wr) r_odata <= w_bad ? 32'h0 : w_load_data;
      end
    end
  end

`ifdef DRAM_RESPONDER_STATS_EN
  logic [31:0] r_rd_cnt, r_wr_cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_rd_cnt <= 32'h0;
      r_wr_cnt <= 32'h0;
    end else if ((r_state == ST_DONE) && !w_bad) begin
      if (r_is_wr) r_wr_cnt <= r_wr_cnt + 32'd1;
      else         r_rd_cnt <= r_rd_cnt + 32'd1;
    end
  end

  assign w_rd_cnt = r_rd_cnt;
  assign w_wr_cnt = r_wr_cnt;
`endif

  assign w_dram_busy  = (r_state != ST_IDLE);
  assign w_dram_odata = r_odata;
  assign w_dram_err   = r_err;
  assign w_dbg_state  = r_state;

endmodule

// File: tb/tb_dram_responder.sv
// Scoreboard bench for dram_responder: a byte-array reference model predicts
// each response; a monitor checks it whenever busy falls.
module tb_dram_responder;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 4096;
  localparam int          LAT   = 2;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] w_dram_addr, w_dram_wdata, w_dram_odata;
  logic        w_dram_we_t, w_dram_le, w_dram_busy, w_dram_err;
  logic [2:0]  w_dram_ctrl;
  logic [1:0]  w_dbg_state;
`ifdef DRAM_RESPONDER_STATS_EN
  logic [31:0] w_rd_cnt, w_wr_cnt;
`endif

  always #5 CLK = ~CLK;

  dram_responder #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .w_dram_addr  (w_dram_addr),
    .w_dram_wdata (w_dram_wdata),
    .w_dram_we_t  (w_dram_we_t),
    .w_dram_le    (w_dram_le),
    .w_dram_ctrl  (w_dram_ctrl),
    .w_dram_odata (w_dram_odata),
    .w_dram_busy  (w_dram_busy),
    .w_dbg_state  (w_dbg_state),
    .w_dram_err   (w_dram_err)
`ifdef DRAM_RESPONDER_STATS_EN
    ,
    .w_rd_cnt     (w_rd_cnt),
    .w_wr_cnt     (w_wr_cnt)
`endif
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [32:0] exp_q[$];

  // Reference model: byte-addressed window plus the last response.
  logic [7:0]  m_mem [4*DEPTH];
  logic [31:0] m_odata = 32'h0;
  logic        m_err = 1'b0;
  int unsigned m_rd = 0;
  int unsigned m_wr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_req(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [2:0] ctrl, output logic [32:0] e);
    logic [31:0] off, v;
    int          size;
    bit          err;
    off  = addr - BASE;
    size = (ctrl[1:0] == 2'd0) ? 1 : (ctrl[1:0] == 2'd1) ? 2 : 4;
    err  = (ctrl == 3'd3) || (ctrl == 3'd6) || (ctrl == 3'd7) ||
           (off >= 32'(4*DEPTH)) || ((off % size) != 0);
    if (wr) begin
      if (!err) begin
        for (int k = 0; k < size; k++) m_mem[off + k] = wdata[8*k +: 8];
        m_wr++;
      end
    end else if (err) begin
      m_odata = 32'h0;
    end else begin
      v = 32'h0;
      for (int k = 0; k < size; k++) v = v | (32'(m_mem[off + k]) << (8*k));
      if (!ctrl[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
      m_odata = v;
      m_rd++;
    end
    m_err = err;
    e = {m_err, m_odata};
  endtask

  task automatic wait_idle();
    int n = 0;
    while (w_dram_busy === 1'b1 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 100) begin
      n_checks++;
      n_errors++;
      $display("FAIL busy_timeout: busy still %0b after %0d cycles", w_dram_busy, n);
    end
  endtask

  task automatic req(input bit we, input bit le, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [2:0] ctrl);
    logic [32:0] e;
    wait_idle();
    model_req(we, addr, wdata, ctrl, e);
    exp_q.push_back(e);
    w_dram_we_t  = we;
    w_dram_le    = le;
    w_dram_addr  = addr;
    w_dram_wdata = wdata;
    w_dram_ctrl  = ctrl;
    @(negedge CLK);
    w_dram_we_t = 1'b0;
    w_dram_le   = 1'b0;
  endtask

  // Monitor: every busy fall outside reset is one response.
  bit prev_busy = 1'b0;
  int busy_len  = 0;
  always @(negedge CLK) begin
    logic [32:0] e;
    if (RST !== 1'b0) begin
      prev_busy = 1'b0;
      busy_len  = 0;
    end else begin
      if (w_dram_busy) begin
        busy_len++;
      end else if (prev_busy) begin
        check("busy_len", 32'(busy_len), 32'(LAT));
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_response: odata 0x%08h err %0b with no request outstanding",
                   w_dram_odata, w_dram_err);
        end else begin
          e = exp_q.pop_front();
          check("odata", w_dram_odata, e[31:0]);
          check("err", {31'h0, w_dram_err}, {31'h0, e[32]});
        end
        busy_len = 0;
      end
      prev_busy = w_dram_busy;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [2:0] ld_codes [5];
  logic [2:0] bad_codes [3];
  logic [2:0] st_codes [5];

  initial begin
    logic [31:0] addr, data;
    logic [2:0]  ctrl;
    int          r, op;
    ld_codes  = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    bad_codes = '{3'd3, 3'd6, 3'd7};
    st_codes  = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd3};

    RST = 1'b1;
    w_dram_we_t = 1'b0;
    w_dram_le = 1'b0;
    w_dram_addr = 32'h0;
    w_dram_wdata = 32'h0;
    w_dram_ctrl = 3'd0;
    #12;
    check("reset_busy", {31'h0, w_dram_busy}, 32'h0);
    check("reset_odata", w_dram_odata, 32'h0);
    check("reset_err", {31'h0, w_dram_err}, 32'h0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    // Known contents for the words the random phase touches.
    for (int w = 0; w < 32; w++) req(1'b1, 1'b0, BASE + 32'(4*w), $urandom, 3'd2);
    req(1'b1, 1'b0, BASE + 32'(4*DEPTH - 4), $urandom, 3'd2);

    req(1'b1, 1'b0, BASE + 32'h10, 32'hDEAD_BEEF, 3'd2);
    req(1'b0, 1'b1, BASE + 32'h10, 32'h0, 3'd2);
    req(1'b1, 1'b0, BASE + 32'h10, 32'h0, 3'd2);
    req(1'b1, 1'b0, BASE + 32'h13, 32'h7F, 3'd0);
    req(1'b0, 1'b1, BASE + 32'h10, 32'h0, 3'd2);
    req(1'b0, 1'b1, BASE + 32'h13, 32'h0, 3'd0);
    req(1'b1, 1'b0, BASE + 32'h13, 32'h80, 3'd0);
    req(1'b0, 1'b1, BASE + 32'h13, 32'h0, 3'd0);
    req(1'b0, 1'b1, BASE + 32'h13, 32'h0, 3'd4);
    req(1'b1, 1'b0, BASE + 32'h22, 32'h1234, 3'd1);
    req(1'b0, 1'b1, BASE + 32'h22, 32'h0, 3'd5);
    req(1'b0, 1'b1, BASE + 32'h21, 32'h0, 3'd1);
    req(1'b0, 1'b1, BASE + 32'h20, 32'h0, 3'd2);
    req(1'b1, 1'b0, BASE + 32'h4000, 32'hCAFE_F00D, 3'd2);
    req(1'b0, 1'b1, BASE, 32'h0, 3'd2);
    // Load pulse while busy must be ignored.
    w_dram_le   = 1'b1;
    w_dram_addr = BASE + 32'h10;
    @(negedge CLK);
    w_dram_le = 1'b0;
    req(1'b1, 1'b1, BASE + 32'h30, 32'h5555_AAAA, 3'd2);
    req(1'b0, 1'b1, BASE + 32'h30, 32'h0, 3'd2);

    // Reset while a store is in flight: no commit, busy drops at once.
    wait_idle();
    w_dram_we_t  = 1'b1;
    w_dram_addr  = BASE + 32'h14;
    w_dram_wdata = 32'h1357_9BDF;
    w_dram_ctrl  = 3'd2;
    @(posedge CLK);
    #1;
    check("busy_before_rst", {31'h0, w_dram_busy}, 32'h1);
    #1 RST = 1'b1;
    #1;
    check("rst_busy_async", {31'h0, w_dram_busy}, 32'h0);
    @(negedge CLK);
    w_dram_we_t = 1'b0;
    check("rst_odata", w_dram_odata, 32'h0);
    check("rst_err", {31'h0, w_dram_err}, 32'h0);
    m_odata = 32'h0;
    m_err   = 1'b0;
    m_rd    = 0;
    m_wr    = 0;
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    req(1'b0, 1'b1, BASE + 32'h14, 32'h0, 3'd2);

    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       addr = BASE + $urandom_range(0, 127);
      else if (r == 7) addr = BASE + 32'(4*DEPTH - 4) + $urandom_range(0, 3);
      else if (r == 8) addr = BASE + 32'(4*DEPTH) + $urandom_range(0, 31);
      else             addr = BASE - $urandom_range(1, 16);
      data = $urandom;
      op   = $urandom_range(0, 2);
      if (op == 0) begin
        r    = $urandom_range(0, 9);
        ctrl = (r < 8) ? ld_codes[r % 5] : bad_codes[$urandom_range(0, 2)];
        req(1'b0, 1'b1, addr, data, ctrl);
      end else begin
        ctrl = st_codes[$urandom_range(0, 4)];
        req(1'b1, op == 2, addr, data, ctrl);
      end
    end

    wait_idle();
    @(negedge CLK);
    @(negedge CLK);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
`ifdef DRAM_RESPONDER_STATS_EN
    check("rd_cnt", w_rd_cnt, m_rd);
    check("wr_cnt", w_wr_cnt, m_wr);
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
